// File: rtl/pio_pulse_out_pkg.sv
// -----------------------------------------------------------------------------
// pio_pulse_out_pkg
//   Shared definitions for the pulse-capable PIO output block:
//     - Avalon word addresses of the register map
//     - bit positions inside the STATUS register
//     - pulse FSM state encoding
// -----------------------------------------------------------------------------
package pio_pulse_out_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_SET       = 3'd1;
   localparam logic [2:0] ADDR_CLEAR     = 3'd2;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
   localparam logic [2:0] ADDR_PULSE     = 3'd4;
   localparam logic [2:0] ADDR_STATUS    = 3'd5;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_OVR_BIT  = 1;
   localparam int STATUS_MASK_LSB = 8;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PULSING = 1'b1
   } pulse_state_e;

endpackage

// File: rtl/pio_pulse_out_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
//   Pulse-length down-counter and IDLE/PULSING state machine.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     load         : start a pulse (only honoured in IDLE; caller guarantees
//                    len is nonzero)
//     len          : pulse length in cycles, sampled on load
//     busy         : state == PULSING
//     done         : last cycle of the pulse (PULSING with CNT == 1); the
//                    owner of the pulse mask clears it on this cycle
// -----------------------------------------------------------------------------
module pulse_timer
   import pio_pulse_out_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done
);

   pulse_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;

   // Leaving PULSING when CNT reaches 1 means the decrement never wraps and
   // the pulse lasts exactly len cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  cnt_q   <= len;
                  state_q <= ST_PULSING;
               end
            end
            ST_PULSING: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q == ST_PULSING);
   assign done = busy && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pio_pulse_out.sv
// -----------------------------------------------------------------------------
// pio_pulse_out
//   Avalon-MM parallel output port with SET/CLEAR helpers and a timed
//   XOR pulse on selected bits.
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     address[2:0]      : word address (0 DATA, 1 SET, 2 CLEAR, 3 PULSE_LEN,
//                         4 PULSE, 5 STATUS, 6-7 reserved)
//     chipselect,write_n: write strobe = chipselect & ~write_n
//     writedata[31:0]   : write data
//     readdata[31:0]    : combinational read mux, zero wait states
//     out_port[WIDTH-1:0]: DATA ^ MASK, from registers only
//   Handshake: no valid/ready; a write is accepted on every rising edge where
//   chipselect=1 and write_n=0, reads are always valid in the same cycle.
// -----------------------------------------------------------------------------
module pio_pulse_out
   import pio_pulse_out_pkg::*;
#(
   parameter int               WIDTH       = 1,
   parameter int               CNT_W       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [CNT_W-1:0] LEN_RESET   = CNT_W'(1000)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             ovr_q, ovr_d;

   logic             wr;
   logic [WIDTH-1:0] wbits;
   logic             pulse_wr;
   logic             load;
   logic             busy;
   logic             done;
   logic             ovr_set;
   logic             ovr_clr;
   logic [39:0]      status_w;
   logic             unused_wdata;

   assign wr       = chipselect & ~write_n;
   assign wbits    = writedata[WIDTH-1:0];
   assign pulse_wr = wr && (address == ADDR_PULSE);

   // A pulse starts only from IDLE with a nonzero mask and length; a PULSE
   // write while busy is rejected and flagged as overrun instead.
   assign load    = pulse_wr && !busy && (|wbits) && (|len_q);
   assign ovr_set = pulse_wr && busy;
   assign ovr_clr = wr && (address == ADDR_STATUS) && writedata[STATUS_OVR_BIT];

   // Wide data bits beyond the register widths are intentionally ignored.
   assign unused_wdata = ^writedata;

   pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .len     (len_q),
      .busy    (busy),
      .done    (done)
   );

   always_comb begin
      data_d = data_q;
      len_d  = len_q;
      mask_d = mask_q;
      ovr_d  = ovr_q;

      if (wr) begin
         case (address)
            ADDR_DATA:      data_d = wbits;
            ADDR_SET:       data_d = data_q | wbits;
            ADDR_CLEAR:     data_d = data_q & ~wbits;
            ADDR_PULSE_LEN: len_d  = writedata[CNT_W-1:0];
            default:        ;
         endcase
      end

      // load needs IDLE and done needs PULSING, so they never coincide.
      if (load) begin
         mask_d = wbits;
      end else if (done) begin
         mask_d = '0;
      end

      // Set has priority over a same-cycle clear.
      if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         len_q  <= LEN_RESET;
         mask_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         len_q  <= len_d;
         mask_q <= mask_d;
         ovr_q  <= ovr_d;
      end
   end

   assign out_port = data_q ^ mask_q;

   // STATUS is built 40 bits wide so a 32-bit MASK at bit 8 still elaborates;
   // only the low 32 bits are visible on the bus.
   always_comb begin
      status_w                                       = '0;
      status_w[STATUS_BUSY_BIT]                      = busy;
      status_w[STATUS_OVR_BIT]                       = ovr_q;
      status_w[STATUS_MASK_LSB +: WIDTH]             = mask_q;
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata[WIDTH-1:0] = data_q;
         ADDR_PULSE_LEN: readdata[CNT_W-1:0] = len_q;
         ADDR_STATUS:    readdata            = status_w[31:0];
         default:        readdata            = '0;
      endcase
   end

endmodule

// File: tb/tb_pio_pulse_out.sv
module tb_pio_pulse_out;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;
  localparam logic [CNT_W-1:0] LEN_RST = 16'd1000;

  logic             clk;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_total;
  int n_bad;
  logic [31:0] exp_q[$];

  pio_pulse_out #(
    .WIDTH       (WIDTH),
    .CNT_W       (CNT_W),
    .RESET_VALUE (RST_VAL),
    .LEN_RESET   (LEN_RST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // checking task
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at posedge+1, return at the next posedge+1
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int n;
    n = 0;
    bus_read(3'd5, st);
    while (st[0] && n < 50) begin
      step();
      bus_read(3'd5, st);
      n++;
    end
    check_val(tag, {31'd0, st[0]}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] ex;

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", {24'd0, out_port}, 32'h0000_00A5);
    bus_read(3'd3, rd);
    check_val("rst_len", rd, 32'd1000);
    bus_read(3'd5, rd);
    check_val("rst_status", rd, 32'd0);
    reset_n = 1'b1;
    step();

    // DATA / SET / CLEAR
    bus_write(3'd0, 32'h0000_000F);
    bus_write(3'd1, 32'h0000_0030);
    check_val("set_out", {24'd0, out_port}, 32'h3F);
    bus_write(3'd2, 32'h0000_0003);
    check_val("clr_out", {24'd0, out_port}, 32'h3C);
    bus_read(3'd0, rd);
    check_val("data_rd", rd, 32'h3C);
    bus_read(3'd1, rd);
    check_val("set_rd_zero", rd, 32'd0);
    // reserved address: read 0, writes ignored
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    check_val("rsv_rd", rd, 32'd0);
    bus_read(3'd0, rd);
    check_val("rsv_wr_ignored", rd, 32'h3C);

    // 4-cycle pulse on bit 0
    bus_write(3'd3, 32'd4);
    bus_read(3'd3, rd);
    check_val("len_rd", rd, 32'd4);
    bus_write(3'd0, 32'd0);
    bus_write(3'd4, 32'h01);
    exp_q = {32'h01, 32'h01, 32'h01, 32'h01, 32'h00, 32'h00};
    for (int i = 0; i < 6; i++) begin
      ex = exp_q.pop_front();
      check_val($sformatf("pulse_out[%0d]", i), {24'd0, out_port}, ex);
      bus_read(3'd5, rd);
      check_val($sformatf("pulse_busy[%0d]", i), {31'd0, rd[0]}, {31'd0, ex[0]});
      check_val($sformatf("pulse_mask[%0d]", i), {24'd0, rd[15:8]}, ex);
      step();
    end

    // overrun handling
    bus_write(3'd4, 32'h01);
    bus_write(3'd4, 32'h02);
    check_val("ovr_ignored_out", {24'd0, out_port}, 32'h01);
    bus_read(3'd5, rd);
    check_val("ovr_set", rd, 32'h0000_0103);
    bus_write(3'd5, 32'h2);
    bus_read(3'd5, rd);
    check_val("ovr_cleared", {31'd0, rd[1]}, 32'd0);
    bus_write(3'd4, 32'h02);
    bus_read(3'd5, rd);
    check_val("ovr_reset_again", rd, 32'h0000_0103);
    wait_idle("ovr_pulse_end");
    bus_read(3'd5, rd);
    check_val("ovr_sticky", rd, 32'h0000_0002);
    check_val("ovr_out_after", {24'd0, out_port}, 32'h00);
    bus_write(3'd5, 32'h2);
    bus_read(3'd5, rd);
    check_val("ovr_final_clear", rd, 32'd0);

    // rejected pulses
    bus_write(3'd3, 32'd0);
    bus_write(3'd4, 32'hFF);
    check_val("len0_out", {24'd0, out_port}, 32'h00);
    bus_read(3'd5, rd);
    check_val("len0_busy", rd, 32'd0);
    bus_write(3'd3, 32'd5);
    bus_write(3'd4, 32'h00);
    bus_read(3'd5, rd);
    check_val("mask0_busy", rd, 32'd0);
    step();
    bus_read(3'd5, rd);
    check_val("mask0_busy_later", rd, 32'd0);

    // SET of a bit that is currently pulsing
    bus_write(3'd3, 32'd4);
    bus_write(3'd4, 32'h80);
    check_val("b7_pulse_out", {24'd0, out_port}, 32'h80);
    bus_write(3'd1, 32'h80);
    check_val("b7_set_during", {24'd0, out_port}, 32'h00);
    wait_idle("b7_pulse_end");
    check_val("b7_after", {24'd0, out_port}, 32'h80);

    // reset in the middle of a pulse
    bus_write(3'd0, 32'h00);
    bus_write(3'd3, 32'd10);
    bus_write(3'd4, 32'h80);
    step();
    step();
    check_val("mid_pulse_out", {24'd0, out_port}, 32'h80);
    reset_n = 1'b0;
    #1;
    check_val("async_rst_out", {24'd0, out_port}, 32'hA5);
    bus_read(3'd5, rd);
    check_val("async_rst_status", rd, 32'd0);
    bus_read(3'd3, rd);
    check_val("async_rst_len", rd, 32'd1000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_val($sformatf("post_rst_out[%0d]", i), {24'd0, out_port}, 32'hA5);
    end
    bus_read(3'd5, rd);
    check_val("post_rst_status", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
